// File: rtl/voice_envelope_scheduler.sv
// Time-shared envelope sequencer: after each sample tick, one voice per clock is
// stepped through attack/sustain/release using a single adder and subtractor.
module voice_envelope_scheduler #(
  parameter int VOICES = 4,
  parameter int WIDTH  = 12
) (
  input  logic                      inClk,
  input  logic                      inReset,
  input  logic                      inSampleTick,
  input  logic [VOICES-1:0]         inIsPlaying,
  input  logic [VOICES*WIDTH-1:0]   inTargets,
  input  logic [VOICES*WIDTH-1:0]   inVelocities,
  output logic [VOICES*WIDTH-1:0]   outLevels,
  output logic [VOICES-1:0]         outActive,
  output logic                      outBusy,
  output logic                      outFrameReady,
  output logic                      outOverrun
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic {ST_WAIT, ST_SCAN} sched_e;
  typedef enum logic [1:0] {PH_IDLE, PH_ATTACK, PH_SUSTAIN, PH_RELEASE} phase_e;

  typedef struct packed {
    phase_e           ph;
    logic [WIDTH-1:0] lvl;
  } upd_t;

  sched_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               frame_q, frame_d;
  logic               overrun_q, overrun_d;
  logic [WIDTH-1:0]   level_q [VOICES];
  phase_e             phase_q [VOICES];

  logic               svc_en;
  logic               last_voice;
  logic               sel_play;
  logic [WIDTH-1:0]   sel_lvl, sel_tgt, sel_step;
  phase_e             sel_phase, eff_phase;
  logic [WIDTH:0]     sum, diff;
  upd_t               upd;

  // Attack saturates at the target: zero step, carry out, or overshoot all land on target.
  function automatic upd_t attack_sat(input logic [WIDTH:0]   s,
                                      input logic [WIDTH-1:0] step,
                                      input logic [WIDTH-1:0] tgt);
    upd_t r;
    if (step != '0 && !s[WIDTH] && s[WIDTH-1:0] <= tgt) begin
      r.ph  = PH_ATTACK;
      r.lvl = s[WIDTH-1:0];
    end else begin
      r.ph  = PH_SUSTAIN;
      r.lvl = tgt;
    end
    return r;
  endfunction

  // Release floors at zero; a zero step means an immediate cut to silence.
  function automatic upd_t release_floor(input logic [WIDTH:0]   d,
                                         input logic [WIDTH-1:0] step);
    upd_t r;
    if (step != '0 && !d[WIDTH] && d[WIDTH-1:0] != '0) begin
      r.ph  = PH_RELEASE;
      r.lvl = d[WIDTH-1:0];
    end else begin
      r.ph  = PH_IDLE;
      r.lvl = '0;
    end
    return r;
  endfunction

  assign last_voice = (idx_q == IDX_W'(VOICES - 1));

  // Scheduler state register
  always_ff @(posedge inClk) begin
    if (inReset) begin
      state_q   <= ST_WAIT;
      idx_q     <= '0;
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
    end
  end

  // Scheduler next state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      ST_WAIT: begin
        if (inSampleTick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      default: begin
        if (inSampleTick) overrun_d = 1'b1;
        if (last_voice) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          frame_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  // Scheduler outputs
  always_comb begin
    svc_en        = (state_q == ST_SCAN);
    outBusy       = (state_q == ST_SCAN);
    outFrameReady = frame_q;
    outOverrun    = overrun_q;
  end

  // Shared datapath on the voice currently being serviced
  always_comb begin
    sel_play  = inIsPlaying[idx_q];
    sel_lvl   = level_q[idx_q];
    sel_phase = phase_q[idx_q];
    sel_tgt   = inTargets[int'(idx_q)*WIDTH +: WIDTH];
    sel_step  = inVelocities[int'(idx_q)*WIDTH +: WIDTH];
    sum       = {1'b0, sel_lvl} + {1'b0, sel_step};
    diff      = {1'b0, sel_lvl} - {1'b0, sel_step};

    eff_phase = sel_phase;
    if (sel_play && (sel_phase == PH_IDLE || sel_phase == PH_RELEASE))
      eff_phase = PH_ATTACK;
    else if (!sel_play && (sel_phase == PH_ATTACK || sel_phase == PH_SUSTAIN))
      eff_phase = PH_RELEASE;

    case (eff_phase)
      PH_ATTACK:  upd = attack_sat(sum, sel_step, sel_tgt);
      PH_SUSTAIN: upd = '{ph: PH_SUSTAIN, lvl: sel_tgt};
      PH_RELEASE: upd = release_floor(diff, sel_step);
      default:    upd = '{ph: PH_IDLE, lvl: '0};
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inReset) begin
      for (int v = 0; v < VOICES; v++) begin
        level_q[v] <= '0;
        phase_q[v] <= PH_IDLE;
      end
    end else if (svc_en) begin
      level_q[idx_q] <= upd.lvl;
      phase_q[idx_q] <= upd.ph;
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_out
    assign outLevels[v*WIDTH +: WIDTH] = level_q[v];
    assign outActive[v]                = (phase_q[v] != PH_IDLE);
  end

endmodule

// File: tb/tb_voice_envelope_scheduler.sv
// Bench for voice_envelope_scheduler: directed envelope scenarios plus random frames
// compared against a frame-level arithmetic model of the envelope rules.
module tb_voice_envelope_scheduler;

  localparam int V = 4;
  localparam int W = 12;

  logic           clk;
  logic           rst;
  logic           tick;
  logic [V-1:0]   playing;
  logic [V*W-1:0] targets;
  logic [V*W-1:0] vels;
  logic [V*W-1:0] levels;
  logic [V-1:0]   active;
  logic           busy;
  logic           frame;
  logic           overrun;

  int checks = 0;
  int fails  = 0;

  // Model: per-voice level and mode (0 silent, 1 rising, 2 holding, 3 falling)
  int m_lvl [V];
  int m_mode[V];
  int play_a[V];
  int tgt_a [V];
  int vel_a [V];

  voice_envelope_scheduler #(.VOICES(V), .WIDTH(W)) dut (
    .inClk        (clk),
    .inReset      (rst),
    .inSampleTick (tick),
    .inIsPlaying  (playing),
    .inTargets    (targets),
    .inVelocities (vels),
    .outLevels    (levels),
    .outActive    (active),
    .outBusy      (busy),
    .outFrameReady(frame),
    .outOverrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int v = 0; v < V; v++) begin
      playing[v]         = (play_a[v] != 0);
      targets[v*W +: W]  = W'(tgt_a[v]);
      vels[v*W +: W]     = W'(vel_a[v]);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_lvl[v]  = 0;
      m_mode[v] = 0;
    end
  endtask

  task automatic model_frame();
    int nxt;
    for (int v = 0; v < V; v++) begin
      if (play_a[v] != 0) begin
        if (m_mode[v] == 0 || m_mode[v] == 3) m_mode[v] = 1;
        if (m_mode[v] == 1) begin
          nxt = m_lvl[v] + vel_a[v];
          if (vel_a[v] == 0 || nxt > tgt_a[v]) begin
            m_lvl[v]  = tgt_a[v];
            m_mode[v] = 2;
          end else begin
            m_lvl[v] = nxt;
          end
        end else begin
          m_lvl[v] = tgt_a[v];
        end
      end else begin
        if (m_mode[v] == 1 || m_mode[v] == 2) m_mode[v] = 3;
        if (m_mode[v] == 3) begin
          nxt = m_lvl[v] - vel_a[v];
          if (vel_a[v] == 0 || nxt <= 0) begin
            m_lvl[v]  = 0;
            m_mode[v] = 0;
          end else begin
            m_lvl[v] = nxt;
          end
        end else begin
          m_lvl[v] = 0;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int v = 0; v < V; v++) begin
      check($sformatf("%s_lvl%0d", tag, v), levels[v*W +: W], m_lvl[v]);
      check($sformatf("%s_act%0d", tag, v), active[v], (m_mode[v] != 0));
    end
  endtask

  // One tick, wait for the frame pulse, then compare against the model.
  task automatic run_frame(input string tag);
    int n;
    @(negedge clk);
    drive_inputs();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    n = 1;
    check({tag, "_busy"}, busy, 1'b1);
    while (!frame && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, V + 1);
    check({tag, "_busy_done"}, busy, 1'b0);
    model_frame();
    check_model(tag);
  endtask

  initial begin
    int n;
    int seen;
    rst  = 1'b1;
    tick = 1'b0;
    for (int v = 0; v < V; v++) begin
      play_a[v] = 0;
      tgt_a[v]  = 0;
      vel_a[v]  = 0;
    end
    drive_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_levels", levels, 0);
    check("rst_active", active, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame", frame, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_frame("idle");
    check("idle_levels", levels, 0);

    play_a = '{1, 1, 1, 1};
    tgt_a  = '{20, 4095, 12, 17};
    vel_a  = '{5, 4090, 0, 0};
    run_frame("a1");
    check("a1_v0", levels[0 +: W], 5);
    check("a1_v1", levels[W +: W], 4090);

    play_a = '{1, 1, 0, 0};
    vel_a  = '{5, 10, 5, 10};
    run_frame("a2");
    check("a2_v0", levels[0 +: W], 10);
    check("a2_v1_clamp", levels[W +: W], 4095);
    check("a2_v2_rel", levels[2*W +: W], 7);
    check("a2_v3_rel", levels[3*W +: W], 7);

    play_a[3] = 1;
    vel_a[3]  = 5;
    tgt_a[3]  = 30;
    run_frame("a3");
    check("a3_v0", levels[0 +: W], 15);
    check("a3_v2", levels[2*W +: W], 2);
    check("a3_v3_retrig", levels[3*W +: W], 12);

    run_frame("a4");
    check("a4_v0", levels[0 +: W], 20);
    check("a4_v2", levels[2*W +: W], 0);
    check("a4_v3", levels[3*W +: W], 17);
    check("a4_active", active, 4'b1011);

    run_frame("a5");
    check("a5_v0", levels[0 +: W], 20);

    play_a[0] = 0;
    vel_a[0]  = 0;
    run_frame("cut");
    check("cut_v0", levels[0 +: W], 0);

    play_a[0] = 1;
    tgt_a[0]  = 4095;
    vel_a[0]  = 4000;
    run_frame("big1");
    check("big1_v0", levels[0 +: W], 4000);
    run_frame("big2");
    check("big2_v0_carry", levels[0 +: W], 4095);
    check("no_overrun_b2b", overrun, 1'b0);

    // Second tick two cycles into the scan
    @(negedge clk);
    drive_inputs();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    n = 1;
    @(posedge clk);
    #1;
    n++;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    n++;
    while (!frame && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ovr_latency", n, V + 1);
    check("ovr_flag", overrun, 1'b1);
    model_frame();
    check_model("ovr");
    @(posedge clk);
    #1;
    check("ovr_single_frame", frame, 1'b0);
    run_frame("ovr_next");
    check("ovr_sticky", overrun, 1'b1);

    // Reset in the middle of a scan
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_levels", levels, 0);
    check("mrst_active", active, 0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_frame", frame, 1'b0);
    check("mrst_overrun", overrun, 1'b0);
    model_reset();
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (frame) seen++;
    end
    check("mrst_no_frame", seen, 0);

    for (int f = 0; f < 40; f++) begin
      for (int v = 0; v < V; v++) begin
        play_a[v] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        tgt_a[v]  = $urandom_range(0, 4095);
        case ($urandom_range(0, 3))
          0:       vel_a[v] = 0;
          1:       vel_a[v] = $urandom_range(1, 64);
          2:       vel_a[v] = $urandom_range(1, 4095);
          default: vel_a[v] = $urandom_range(1, 600);
        endcase
      end
      run_frame($sformatf("rnd%0d", f));
    end
    check("rnd_overrun", overrun, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
